// File: rtl/stall_ctrl_param.sv
// Stall controller: decodes load/branch/halt opcodes and drives registered bubble and PC-freeze signals.
// Outputs assert one edge after the opcode is sampled in IDLE; there is no handshake, and ins is ignored while busy.
module stall_ctrl_param #(
  parameter int              INS_W  = 24,
  parameter int              OP_W   = 5,
  parameter logic [OP_W-1:0] LD_OP  = 5'h14,
  parameter logic [OP_W-1:0] BR_OP  = 5'h1E,
  parameter logic [OP_W-1:0] HLT_OP = 5'h11,
  parameter int              LD_CYC = 1,
  parameter int              BR_CYC = 2,
  parameter int              CNT_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INS_W-1:0] ins,
  input  logic             ins_valid,
  input  logic             resume,
  output logic             stall,
  output logic             stall_pm,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  if (LD_CYC < 1 || LD_CYC > 15 || BR_CYC < 1 || BR_CYC > 15 ||
      LD_CYC >= (1 << CNT_W) || BR_CYC >= (1 << CNT_W) || OP_W > INS_W) begin : g_param_check
    $error("stall_ctrl_param: stall length or field width parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, STALL, HALT} state_t;
  typedef enum logic {CLS_LOAD, CLS_BRANCH} cls_t;

  localparam logic [CNT_W-1:0] LD_CNT      = CNT_W'(LD_CYC);
  localparam logic [CNT_W-1:0] BR_CNT      = CNT_W'(BR_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic             BR_PM_FIRST = (BR_CYC > 1);

  state_t           state, state_nxt;
  cls_t             cls, cls_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stall_nxt, pm_nxt, halted_nxt;
  logic [OP_W-1:0]  op;

  assign op = ins[INS_W-1 -: OP_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cls       <= CLS_LOAD;
      stall     <= 1'b0;
      stall_pm  <= 1'b0;
      halted    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cls       <= cls_nxt;
      stall     <= stall_nxt;
      stall_pm  <= pm_nxt;
      halted    <= halted_nxt;
      stall_cnt <= cnt_nxt;
    end
  end

  // stall_cnt doubles as the down-counter; outputs are computed for the next state.
  always_comb begin
    state_nxt  = state;
    cls_nxt    = cls;
    cnt_nxt    = '0;
    stall_nxt  = 1'b0;
    pm_nxt     = 1'b0;
    halted_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (ins_valid) begin
          if (op == HLT_OP) begin
            state_nxt  = HALT;
            stall_nxt  = 1'b1;
            pm_nxt     = 1'b1;
            halted_nxt = 1'b1;
          end else if (op == BR_OP) begin
            state_nxt = STALL;
            cls_nxt   = CLS_BRANCH;
            cnt_nxt   = BR_CNT;
            stall_nxt = 1'b1;
            pm_nxt    = BR_PM_FIRST;
          end else if (op == LD_OP) begin
            state_nxt = STALL;
            cls_nxt   = CLS_LOAD;
            cnt_nxt   = LD_CNT;
            stall_nxt = 1'b1;
            pm_nxt    = 1'b1;
          end
        end
      end
      STALL: begin
        if (stall_cnt == CNT_ONE) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = stall_cnt - CNT_ONE;
          stall_nxt = 1'b1;
          // Branch releases PC on its last stall cycle so the target is fetched then.
          pm_nxt    = (cls == CLS_LOAD) || (cnt_nxt > CNT_ONE);
        end
      end
      HALT: begin
        if (resume) begin
          state_nxt = IDLE;
        end else begin
          stall_nxt  = 1'b1;
          pm_nxt     = 1'b1;
          halted_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
